// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divider.
// - div_state_t : FSM state encoding (IDLE, RUN, FIX, DONE), 2 bits.
// - cond_neg    : two's-complement conditional negate, used for both
//                 taking magnitudes and applying result signs.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Widest operand the helpers handle.
  localparam int unsigned MAX_W = 64;

  // Callers zero-extend a WIDTH-bit value to MAX_W and truncate the result
  // back to WIDTH. The low WIDTH bits of a two's-complement negate depend only
  // on the low WIDTH bits of the input, so this works for any WIDTH <= MAX_W.
  function automatic logic [MAX_W-1:0] twos_neg(input logic [MAX_W-1:0] v);
    return ~v + MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v,
                                                input logic             neg);
    return neg ? twos_neg(v) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational.
// Ports:
//   a      : partial remainder (always < d)
//   q      : dividend bits still to shift in / quotient bits so far
//   d      : divisor magnitude
//   a_next : partial remainder after this iteration
//   q_next : q shifted left with the new quotient bit in bit 0
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] a_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0]   a_sh;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // The sign of a WIDTH+1-bit trial subtraction is expressed here as a
  // WIDTH+1-bit compare; when the divisor fits, the true difference is below
  // d, so the low WIDTH bits of the modular difference are exact.
  always_comb begin
    a_sh = {a, q[WIDTH-1]};
    fits = (a_sh >= {1'b0, d});
    diff = a_sh[WIDTH-1:0] - d;
    if (fits) begin
      a_next = diff;
      q_next = {q[WIDTH-2:0], 1'b1};
    end else begin
      a_next = a_sh[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq_param.sv
// Parametrised sequential restoring divider with start/busy/ready handshake.
// Signed or unsigned operation, quotient and remainder outputs, separate
// divide-by-zero and signed-overflow flags.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   start               : request, accepted only when busy=0
//   is_signed           : 1 = two's-complement operands (latched on start)
//   dividend, divisor   : operands (latched on start)
//   busy                : operation in flight (RUN/FIX)
//   ready               : one-cycle pulse when results become valid
//   quotient, remainder : results, held until the next accepted start
//   div_by_zero         : divisor was zero
//   overflow            : signed MIN / -1
// Normal latency is WIDTH+2 edges from the start edge; the zero-divisor and
// overflow cases complete in one edge. WIDTH must be in 4..64.
module div_seq_param
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state, state_next;
  logic [WIDTH-1:0] a_reg, q_reg, d_reg;
  logic [WIDTH-1:0] a_next, q_next;
  logic [CNT_W-1:0] cnt;
  logic             neg_quot, neg_rem;
  logic             accept, is_zero, is_ovf, last_iter;

  div_step #(.WIDTH(WIDTH)) u_step (
    .a      (a_reg),
    .q      (q_reg),
    .d      (d_reg),
    .a_next (a_next),
    .q_next (q_next)
  );

  always_comb begin
    accept    = start && (state == IDLE || state == DONE);
    is_zero   = (divisor == '0);
    is_ovf    = is_signed && (dividend == MIN_VAL) && (divisor == '1);
    last_iter = (cnt == CNT_W'(WIDTH - 1));
    busy      = (state == RUN) || (state == FIX);
    ready     = (state == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_next = (is_zero || is_ovf) ? DONE : RUN;
        else        state_next = IDLE;
      end
      RUN:     if (last_iter) state_next = FIX;
      FIX:     state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      cnt         <= '0;
      neg_quot    <= 1'b0;
      neg_rem     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            if (is_zero) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else if (is_ovf) begin
              quotient  <= MIN_VAL;
              remainder <= '0;
              overflow  <= 1'b1;
            end else begin
              a_reg    <= '0;
              q_reg    <= WIDTH'(cond_neg(MAX_W'(dividend), is_signed & dividend[WIDTH-1]));
              d_reg    <= WIDTH'(cond_neg(MAX_W'(divisor), is_signed & divisor[WIDTH-1]));
              cnt      <= '0;
              neg_quot <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              neg_rem  <= is_signed & dividend[WIDTH-1];
            end
          end
        end
        RUN: begin
          a_reg <= a_next;
          q_reg <= q_next;
          cnt   <= cnt + CNT_W'(1);
        end
        FIX: begin
          quotient  <= WIDTH'(cond_neg(MAX_W'(q_reg), neg_quot));
          remainder <= WIDTH'(cond_neg(MAX_W'(a_reg), neg_rem));
        end
        default: ;
      endcase
    end
  end

endmodule
